// File: rtl/psum_drain_pkg.sv
// Shared configuration and storage types for the partial-sum drain.
// Lane counts, widths and FIFO depth live here so every file sees one set of values.
package psum_drain_pkg;

    localparam int unsigned PEROW   = 16;
    localparam int unsigned PSUMDWD = 24;
    localparam int unsigned DWD     = 8;
    localparam int unsigned OUTN    = 4;
    localparam int unsigned DEPTH   = 2;

    localparam int unsigned NBEAT = PEROW / OUTN;
    localparam int unsigned PTRW  = $clog2(DEPTH);
    localparam int unsigned CNTW  = $clog2(DEPTH + 1);
    localparam int unsigned BEATW = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam int unsigned SHW   = 5;

    typedef logic [PEROW-1:0][PSUMDWD-1:0]             psum_vec_t;
    typedef logic [OUTN-1:0][PSUMDWD-1:0]              beat_t;
    // Same bits as psum_vec_t, viewed as NBEAT beats of OUTN lanes.
    typedef logic [NBEAT-1:0][OUTN-1:0][PSUMDWD-1:0]   psum_beats_t;

    typedef struct packed {
        psum_vec_t        psum;
        logic             last;
        logic [SHW-1:0]   shift;
        logic             relu;
    } drain_entry_t;

    // Shifts past the psum width collapse onto the widest meaningful shift.
    function automatic logic [SHW-1:0] clamp_shift(logic [SHW-1:0] s);
        if (32'(s) >= PSUMDWD) begin
            return SHW'(PSUMDWD - 1);
        end
        return s;
    endfunction

endpackage

// File: rtl/psum_drain_if.sv
// Handshake bundle for the drain: upstream POUT vector channel plus the
// serialized output beat channel. The master drives vectors and Out_ack.
interface psum_drain_if;
    import psum_drain_pkg::*;

    logic             POUT_rdy;
    logic             POUT_ack;
    psum_vec_t        i_Psum;
    logic             i_last;
    logic [SHW-1:0]   i_shift;
    logic             i_relu;

    logic             Out_rdy;
    logic             Out_ack;
    beat_t            o_data;
    logic             o_quant;
    logic             o_eov;
    logic [CNTW-1:0]  o_count;

    modport master (
        output POUT_rdy, i_Psum, i_last, i_shift, i_relu, Out_ack,
        input  POUT_ack, Out_rdy, o_data, o_quant, o_eov, o_count
    );

    modport slave (
        input  POUT_rdy, i_Psum, i_last, i_shift, i_relu, Out_ack,
        output POUT_ack, Out_rdy, o_data, o_quant, o_eov, o_count
    );

endinterface

// File: rtl/psum_quant.sv
// Single-lane combinational quantizer: round-half-up arithmetic shift,
// optional ReLU, then saturate to DWD bits and sign-extend back to PSUMDWD.
module psum_quant
    import psum_drain_pkg::*;
(
    input  logic [PSUMDWD-1:0] psum_i,
    input  logic [SHW-1:0]     shift_i,
    input  logic               relu_i,
    output logic [PSUMDWD-1:0] quant_o
);

    localparam int unsigned W = PSUMDWD;
    localparam logic signed [W:0] SatMax = (W+1)'((1 << (DWD - 1)) - 1);
    localparam logic signed [W:0] SatMin = ~SatMax;

    logic [SHW-1:0]    sh;
    logic signed [W:0] ext;
    logic signed [W:0] half;
    logic signed [W:0] r;

    always_comb begin
        sh   = clamp_shift(shift_i);
        // One guard bit keeps the rounding add from wrapping.
        ext  = $signed({psum_i[W-1], psum_i});
        half = '0;
        r    = ext;
        if (sh != '0) begin
            half = (W+1)'(1) << (sh - SHW'(1));
            r    = (ext + half) >>> sh;
        end
        if (relu_i && r[W]) begin
            r = '0;
        end
        if (r > SatMax) begin
            r = SatMax;
        end else if (r < SatMin) begin
            r = SatMin;
        end
        quant_o = r[W-1:0];
    end

endmodule

// File: rtl/psum_drain.sv
// Buffers whole psum vectors from a PE column and serializes each onto an
// OUTN-lane output bus, quantizing vectors flagged as last on the read path.
module psum_drain
    import psum_drain_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst,
    psum_drain_if.slave   bus
);

    drain_entry_t      mem_q [DEPTH];
    logic [PTRW-1:0]   wptr_q;
    logic [PTRW-1:0]   rptr_q;
    logic [CNTW-1:0]   count_q;
    logic [BEATW-1:0]  beat_q;

    logic              push;
    logic              step;
    logic              pop;
    logic              eov;
    drain_entry_t      rd_entry;
    psum_beats_t       rd_beats;
    beat_t             raw_beat;
    beat_t             quant_beat;

    // Ack looks only at registered occupancy: a full FIFO refuses even when
    // the head vector finishes draining in the same cycle.
    assign bus.POUT_ack = !i_rst && (count_q < CNTW'(DEPTH));
    assign bus.Out_rdy  = !i_rst && (count_q != '0);
    assign bus.o_count  = i_rst ? '0 : count_q;

    assign eov  = (beat_q == BEATW'(NBEAT - 1));
    assign push = bus.POUT_rdy && bus.POUT_ack;
    assign step = bus.Out_rdy && bus.Out_ack;
    assign pop  = step && eov;

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wptr_q] <= '{psum:  bus.i_Psum,
                               last:  bus.i_last,
                               shift: bus.i_shift,
                               relu:  bus.i_relu};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            beat_q  <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + PTRW'(1);
            end
            if (step) begin
                if (eov) begin
                    beat_q <= '0;
                    rptr_q <= rptr_q + PTRW'(1);
                end else begin
                    beat_q <= beat_q + BEATW'(1);
                end
            end
            if (push && !pop) begin
                count_q <= count_q + CNTW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNTW'(1);
            end
        end
    end

    always_comb begin
        rd_entry = mem_q[rptr_q];
        rd_beats = psum_beats_t'(rd_entry.psum);
        raw_beat = rd_beats[beat_q];
    end

    for (genvar k = 0; k < OUTN; k++) begin : g_lane
        psum_quant u_quant (
            .psum_i  (raw_beat[k]),
            .shift_i (rd_entry.shift),
            .relu_i  (rd_entry.relu),
            .quant_o (quant_beat[k])
        );
    end

    assign bus.o_data  = rd_entry.last ? quant_beat : raw_beat;
    assign bus.o_quant = rd_entry.last;
    assign bus.o_eov   = eov;

endmodule

// File: tb/tb_psum_drain.sv
// Directed and randomized checks of psum_drain against a queue-based model
// of buffered vectors and an integer-arithmetic quantizer.
module tb_psum_drain;
    import psum_drain_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    psum_drain_if bus ();

    psum_drain dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    drain_entry_t src[$];
    drain_entry_t mq[$];
    int           beat;
    int           total;
    int           bad;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Round-half-up divide by 2^sh with floor semantics, then relu and clip.
    function automatic longint qref(longint p, int sh_in, bit relu);
        longint r;
        longint d;
        longint num;
        int     sh;
        sh = (sh_in > int'(PSUMDWD) - 1) ? int'(PSUMDWD) - 1 : sh_in;
        r  = p;
        if (sh > 0) begin
            d   = longint'(1) << sh;
            num = p + d / 2;
            r   = num / d;
            if ((num % d) != 0 && num < 0) r = r - 1;
        end
        if (relu && r < 0) r = 0;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    function automatic beat_t exp_beat(drain_entry_t e, int b);
        beat_t  o;
        longint p;
        longint v;
        for (int k = 0; k < int'(OUTN); k++) begin
            p = longint'($signed(e.psum[b * int'(OUTN) + k]));
            v = e.last ? qref(p, int'(e.shift), e.relu) : p;
            o[k] = v[PSUMDWD-1:0];
        end
        return o;
    endfunction

    function automatic drain_entry_t rand_entry(bit last, int sh, bit relu);
        drain_entry_t e;
        for (int i = 0; i < int'(PEROW); i++) begin
            if ($urandom_range(0, 3) == 0) e.psum[i] = PSUMDWD'($urandom);
            else e.psum[i] = PSUMDWD'(int'($urandom_range(0, 6000)) - 3000);
        end
        e.last  = last;
        e.shift = SHW'(sh);
        e.relu  = relu;
        return e;
    endfunction

    // One cycle per iteration: drive at negedge, check, advance the model.
    // mode: 0 Out_ack low, 1 Out_ack high, 2 random.
    task automatic run(input int n, input int mode, input bit rst_v);
        bit ack;
        bit push;
        bit pop;
        for (int c = 0; c < n; c++) begin
            ack = (mode == 2) ? bit'($urandom_range(0, 1)) : (mode == 1);
            rst = rst_v;
            bus.Out_ack  = ack;
            bus.POUT_rdy = (src.size() > 0);
            if (src.size() > 0) begin
                bus.i_Psum  = src[0].psum;
                bus.i_last  = src[0].last;
                bus.i_shift = src[0].shift;
                bus.i_relu  = src[0].relu;
            end else begin
                bus.i_Psum  = '0;
                bus.i_last  = 1'b0;
                bus.i_shift = '0;
                bus.i_relu  = 1'b0;
            end
            #1;
            if (rst_v) begin
                chk("rst_out_rdy", bus.Out_rdy, 0);
                chk("rst_pout_ack", bus.POUT_ack, 0);
                chk("rst_count", bus.o_count, 0);
                mq.delete();
                beat = 0;
            end else begin
                chk("out_rdy", bus.Out_rdy, mq.size() > 0);
                chk("pout_ack", bus.POUT_ack, mq.size() < int'(DEPTH));
                chk("count", bus.o_count, mq.size());
                if (mq.size() > 0) begin
                    chk("data", bus.o_data, exp_beat(mq[0], beat));
                    chk("quant", bus.o_quant, mq[0].last);
                    chk("eov", bus.o_eov, beat == int'(NBEAT) - 1);
                end
                push = (src.size() > 0) && (mq.size() < int'(DEPTH));
                pop  = (mq.size() > 0) && ack;
                if (pop) begin
                    if (beat == int'(NBEAT) - 1) begin
                        void'(mq.pop_front());
                        beat = 0;
                    end else begin
                        beat++;
                    end
                end
                if (push) mq.push_back(src.pop_front());
            end
            @(negedge clk);
        end
    endtask

    initial begin
        drain_entry_t e;
        total = 0;
        bad   = 0;
        beat  = 0;
        rst   = 1'b1;
        bus.POUT_rdy = 1'b0;
        bus.Out_ack  = 1'b0;
        bus.i_Psum   = '0;
        bus.i_last   = 1'b0;
        bus.i_shift  = '0;
        bus.i_relu   = 1'b0;
        @(negedge clk);
        run(2, 1, 1'b1);

        // Raw passthrough: lane i = i*1000-5000.
        for (int i = 0; i < int'(PEROW); i++) e.psum[i] = PSUMDWD'(i * 1000 - 5000);
        e.last = 1'b0; e.shift = '0; e.relu = 1'b0;
        src.push_back(e);
        run(6, 1, 1'b0);

        // Quantize with rounding and saturation, then the same with ReLU.
        e = rand_entry(1'b1, 4, 1'b0);
        e.psum[0] = PSUMDWD'(40);   e.psum[1] = PSUMDWD'(-40);
        e.psum[2] = PSUMDWD'(24);   e.psum[3] = PSUMDWD'(-24);
        e.psum[4] = PSUMDWD'(2047); e.psum[5] = PSUMDWD'(-5000);
        src.push_back(e);
        run(6, 1, 1'b0);
        e.relu = 1'b1;
        src.push_back(e);
        run(6, 1, 1'b0);

        // Backpressure: three vectors against a stalled output.
        for (int i = 0; i < 3; i++) src.push_back(rand_entry(1'b0, 0, 1'b0));
        run(5, 0, 1'b0);
        run(14, 1, 1'b0);

        // Concurrent push with the eov pop; each vector keeps its own config.
        src.push_back(rand_entry(1'b1, 3, 1'b0));
        run(1, 1, 1'b0);
        run(3, 1, 1'b0);
        src.push_back(rand_entry(1'b1, 6, 1'b1));
        run(1, 1, 1'b0);
        run(5, 1, 1'b0);

        // Random stream with random stalls and shifts beyond the psum width.
        for (int i = 0; i < 30; i++) begin
            src.push_back(rand_entry(bit'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                                     bit'($urandom_range(0, 1))));
        end
        for (int i = 0; i < 2000 && (src.size() > 0 || mq.size() > 0); i++) run(1, 2, 1'b0);
        chk("stream_drained", src.size() + mq.size(), 0);

        // Reset part way through a vector, then a fresh vector from beat 0.
        src.push_back(rand_entry(1'b0, 0, 1'b0));
        run(3, 1, 1'b0);
        src.push_back(rand_entry(1'b1, 2, 1'b0));
        run(1, 1, 1'b1);
        run(7, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
